// File: rtl/stepper_multi_axis_pkg.sv
// Shared types and constants for the multi-axis step/direction generator.
package stepper_pkg;

  typedef enum logic [1:0] {AX_IDLE, AX_SETUP, AX_HIGH, AX_LOW} axis_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/stepper_multi_axis_if.sv
// Per-axis move command bus: valid/ready handshake with direction and step count.
interface stepper_multi_axis_if #(
  parameter int NUM_AXES = 3,
  parameter int STEP_W   = 16
);
  logic [NUM_AXES-1:0]        cmd_valid;
  logic [NUM_AXES-1:0]        cmd_ready;
  logic [NUM_AXES-1:0]        cmd_dir;
  logic [NUM_AXES*STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/stepper_axis.sv
// One stepper channel: DIR setup delay, fixed-rate STEP train, remaining-step and position counters.
//   state    | meaning
//   AX_IDLE  | ready for a command; done/aborted pulse in the first IDLE cycle after a move
//   AX_SETUP | DIR settled, waiting DIR_SETUP clocks before the first STEP rise
//   AX_HIGH  | STEP high for HALF_PERIOD clocks; position moved on entry
//   AX_LOW   | STEP low for HALF_PERIOD clocks; remaining decremented on the last clock
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int POS_W       = 24,
  parameter int HALF_PERIOD = 50000,
  parameter int DIR_SETUP   = 100
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              cmd_valid_i,
  input  logic              cmd_dir_i,
  input  logic [STEP_W-1:0] cmd_steps_i,
  output logic              cmd_ready_o,
  input  logic              abort_i,
  input  logic              zero_pos_i,
  output logic              step_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [POS_W-1:0]  pos_o
);

  localparam int TMR_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);

  axis_state_t       state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [STEP_W-1:0] rem_q;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, step_q, done_q, aborted_q, abort_q;
  logic              last_step_d, enter_high_d;

  // A pending abort turns the current LOW into the last one; the HIGH in flight is never cut.
  always_comb begin
    last_step_d  = (rem_q == STEP_W'(1)) || abort_q || abort_i;
    enter_high_d = (timer_q == '0) &&
                   (((state_q == AX_SETUP) && !abort_i) ||
                    ((state_q == AX_LOW) && !last_step_d));
    pos_d = pos_q;
    if (zero_pos_i)        pos_d = '0;
    else if (enter_high_d) pos_d = (dir_q == DIR_CW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= AX_IDLE;
      timer_q   <= '0;
      rem_q     <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_CCW;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pos_q     <= pos_d;
      case (state_q)
        AX_IDLE: begin
          if (cmd_valid_i) begin
            dir_q   <= cmd_dir_i;
            rem_q   <= cmd_steps_i;
            abort_q <= 1'b0;
            if (cmd_steps_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= AX_SETUP;
              timer_q <= SETUP_LOAD;
            end
          end
        end
        AX_SETUP: begin
          if (abort_i) begin
            state_q   <= AX_IDLE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (enter_high_d) begin
            state_q <= AX_HIGH;
            step_q  <= 1'b1;
            timer_q <= HALF_LOAD;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        AX_HIGH: begin
          if (abort_i) abort_q <= 1'b1;
          if (timer_q == '0) begin
            state_q <= AX_LOW;
            step_q  <= 1'b0;
            timer_q <= HALF_LOAD;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        AX_LOW: begin
          if (timer_q == '0) begin
            rem_q <= rem_q - STEP_W'(1);
            if (last_step_d) begin
              state_q   <= AX_IDLE;
              done_q    <= 1'b1;
              aborted_q <= abort_q | abort_i;
            end else begin
              state_q <= AX_HIGH;
              step_q  <= 1'b1;
              timer_q <= HALF_LOAD;
            end
          end else begin
            timer_q <= timer_q - TMR_W'(1);
            if (abort_i) abort_q <= 1'b1;
          end
        end
        default: state_q <= AX_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == AX_IDLE);
  assign busy_o      = (state_q != AX_IDLE);
  assign step_o      = step_q;
  assign dir_o       = dir_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign pos_o       = pos_q;

endmodule

// File: rtl/stepper_multi_axis.sv
// N independent step/direction channels for A4988-class drivers; packs per-axis counts and positions.
module stepper_multi_axis
  import stepper_pkg::*;
#(
  parameter int NUM_AXES    = 3,
  parameter int STEP_W      = 16,
  parameter int POS_W       = 24,
  parameter int HALF_PERIOD = 50000,
  parameter int DIR_SETUP   = 100
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  stepper_multi_axis_if.slave       cmd,
  input  logic [NUM_AXES-1:0]       abort,
  input  logic [NUM_AXES-1:0]       zero_pos,
  output logic [NUM_AXES-1:0]       step,
  output logic [NUM_AXES-1:0]       dir,
  output logic [NUM_AXES-1:0]       busy,
  output logic [NUM_AXES-1:0]       done,
  output logic [NUM_AXES-1:0]       aborted,
  output logic [NUM_AXES*POS_W-1:0] pos
);

  logic [NUM_AXES-1:0] ready_w;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    stepper_axis #(
      .STEP_W      (STEP_W),
      .POS_W       (POS_W),
      .HALF_PERIOD (HALF_PERIOD),
      .DIR_SETUP   (DIR_SETUP)
    ) u_axis (
      .CLOCK_50    (CLOCK_50),
      .reset_n     (reset_n),
      .cmd_valid_i (cmd.cmd_valid[i]),
      .cmd_dir_i   (cmd.cmd_dir[i]),
      .cmd_steps_i (cmd.cmd_steps[i*STEP_W +: STEP_W]),
      .cmd_ready_o (ready_w[i]),
      .abort_i     (abort[i]),
      .zero_pos_i  (zero_pos[i]),
      .step_o      (step[i]),
      .dir_o       (dir[i]),
      .busy_o      (busy[i]),
      .done_o      (done[i]),
      .aborted_o   (aborted[i]),
      .pos_o       (pos[i*POS_W +: POS_W])
    );
  end

  assign cmd.cmd_ready = ready_w;

endmodule

// File: tb/tb_stepper_multi_axis.sv
// Directed bench for stepper_multi_axis with HALF_PERIOD=4, DIR_SETUP=2; k counts cycles after acceptance.
module tb_stepper_multi_axis;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic [2:0]  abort, zero_pos, step, dir, busy, done, aborted;
  logic [71:0] pos;
  int          vectors = 0;
  int          miscompares = 0;

  stepper_multi_axis_if #(.NUM_AXES(3), .STEP_W(16)) cmd_if ();

  stepper_multi_axis #(
    .NUM_AXES(3), .STEP_W(16), .POS_W(24), .HALF_PERIOD(4), .DIR_SETUP(2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .cmd      (cmd_if),
    .abort    (abort),
    .zero_pos (zero_pos),
    .step     (step),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .pos      (pos)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Called at a negedge; returns at the negedge of the first cycle after acceptance (k=1).
  task automatic start_cmd(input logic [2:0] mask, input logic [2:0] dirs, input logic [47:0] steps);
    cmd_if.cmd_valid = mask;
    cmd_if.cmd_dir   = dirs;
    cmd_if.cmd_steps = steps;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cmd_if.cmd_valid = 3'b000;
  endtask

  task automatic test_reset();
    vectors += 7;
    if (step !== 3'b000)    begin miscompares++; $display("FAIL reset_step: got %b expected 000", step); end
    if (dir !== 3'b000)     begin miscompares++; $display("FAIL reset_dir: got %b expected 000", dir); end
    if (busy !== 3'b000)    begin miscompares++; $display("FAIL reset_busy: got %b expected 000", busy); end
    if (done !== 3'b000)    begin miscompares++; $display("FAIL reset_done: got %b expected 000", done); end
    if (aborted !== 3'b000) begin miscompares++; $display("FAIL reset_aborted: got %b expected 000", aborted); end
    if (pos !== 72'h0)      begin miscompares++; $display("FAIL reset_pos: got %h expected 0", pos); end
    if (cmd_if.cmd_ready !== 3'b111) begin miscompares++; $display("FAIL reset_ready: got %b expected 111", cmd_if.cmd_ready); end
  endtask

  task automatic test_single_move();
    logic exp_step;
    start_cmd(3'b001, 3'b001, {16'd0, 16'd0, 16'd3});
    vectors++;
    if (dir[0] !== 1'b1) begin miscompares++; $display("FAIL single_dir: got %b expected 1", dir[0]); end
    for (int k = 1; k <= 30; k++) begin
      exp_step = (k >= 3 && k <= 6) || (k >= 11 && k <= 14) || (k >= 19 && k <= 22);
      vectors += 3;
      if (step[0] !== exp_step) begin miscompares++; $display("FAIL single_step k=%0d: got %b expected %b", k, step[0], exp_step); end
      if (done[0] !== (k == 27)) begin miscompares++; $display("FAIL single_done k=%0d: got %b expected %b", k, done[0], k == 27); end
      if (busy[0] !== (k < 27)) begin miscompares++; $display("FAIL single_busy k=%0d: got %b expected %b", k, busy[0], k < 27); end
      if (k == 3) begin
        vectors++;
        if (pos[23:0] !== 24'd1) begin miscompares++; $display("FAIL single_pos_first: got %0d expected 1", pos[23:0]); end
      end
      if (k == 27) begin
        vectors += 3;
        if (pos[23:0] !== 24'd3) begin miscompares++; $display("FAIL single_pos: got %0d expected 3", pos[23:0]); end
        if (aborted[0] !== 1'b0) begin miscompares++; $display("FAIL single_aborted: got %b expected 0", aborted[0]); end
        if (cmd_if.cmd_ready[0] !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b expected 1", cmd_if.cmd_ready[0]); end
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_step;
    start_cmd(3'b010, 3'b000, {16'd0, 16'd2, 16'd0});
    for (int k = 1; k <= 40; k++) begin
      exp_step = (k >= 3 && k <= 6) || (k >= 11 && k <= 14) || (k >= 22 && k <= 25) || (k >= 30 && k <= 33);
      vectors += 2;
      if (step[1] !== exp_step) begin miscompares++; $display("FAIL b2b_step k=%0d: got %b expected %b", k, step[1], exp_step); end
      if (done[1] !== (k == 19 || k == 38)) begin miscompares++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, done[1], k == 19 || k == 38); end
      if (k == 19) begin
        vectors += 3;
        if (dir[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_dir_first: got %b expected 0", dir[1]); end
        if (pos[47:24] !== 24'hFFFFFE) begin miscompares++; $display("FAIL b2b_pos_mid: got %h expected fffffe", pos[47:24]); end
        if (cmd_if.cmd_ready[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b expected 1", cmd_if.cmd_ready[1]); end
        cmd_if.cmd_valid[1] = 1'b1;
        cmd_if.cmd_dir[1]   = 1'b1;
        cmd_if.cmd_steps[31:16] = 16'd2;
      end
      if (k == 20) begin
        cmd_if.cmd_valid[1] = 1'b0;
        vectors += 2;
        if (dir[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_dir_second: got %b expected 1", dir[1]); end
        if (busy[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy[1]); end
      end
      if (k == 38) begin
        vectors += 2;
        if (pos[47:24] !== 24'd0) begin miscompares++; $display("FAIL b2b_pos_end: got %h expected 0", pos[47:24]); end
        if (aborted[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_aborted: got %b expected 0", aborted[1]); end
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_abort();
    logic exp_step;
    start_cmd(3'b100, 3'b100, {16'd5, 16'd0, 16'd0});
    for (int k = 1; k <= 30; k++) begin
      abort[2] = (k == 12);
      exp_step = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
      vectors += 2;
      if (step[2] !== exp_step) begin miscompares++; $display("FAIL abort_step k=%0d: got %b expected %b", k, step[2], exp_step); end
      if (done[2] !== (k == 19)) begin miscompares++; $display("FAIL abort_done k=%0d: got %b expected %b", k, done[2], k == 19); end
      if (k == 19) begin
        vectors += 2;
        if (aborted[2] !== 1'b1) begin miscompares++; $display("FAIL abort_flag: got %b expected 1", aborted[2]); end
        if (pos[71:48] !== 24'd2) begin miscompares++; $display("FAIL abort_pos: got %0d expected 2", pos[71:48]); end
      end
      @(negedge CLOCK_50);
    end
    abort = 3'b000;
  endtask

  task automatic test_zero_steps();
    start_cmd(3'b001, 3'b000, {16'd0, 16'd0, 16'd0});
    vectors += 5;
    if (done[0] !== 1'b1)    begin miscompares++; $display("FAIL zero_done: got %b expected 1", done[0]); end
    if (aborted[0] !== 1'b0) begin miscompares++; $display("FAIL zero_aborted: got %b expected 0", aborted[0]); end
    if (dir[0] !== 1'b0)     begin miscompares++; $display("FAIL zero_dir: got %b expected 0", dir[0]); end
    if (busy[0] !== 1'b0)    begin miscompares++; $display("FAIL zero_busy: got %b expected 0", busy[0]); end
    if (pos[23:0] !== 24'd3) begin miscompares++; $display("FAIL zero_pos_kept: got %0d expected 3", pos[23:0]); end
    for (int k = 2; k <= 6; k++) begin
      @(negedge CLOCK_50);
      vectors += 2;
      if (step[0] !== 1'b0) begin miscompares++; $display("FAIL zero_step k=%0d: got %b expected 0", k, step[0]); end
      if (done[0] !== 1'b0) begin miscompares++; $display("FAIL zero_done_after k=%0d: got %b expected 0", k, done[0]); end
    end
  endtask

  task automatic test_parallel();
    zero_pos = 3'b111;
    @(negedge CLOCK_50);
    zero_pos = 3'b000;
    vectors++;
    if (pos !== 72'h0) begin miscompares++; $display("FAIL par_zero_all: got %h expected 0", pos); end
    start_cmd(3'b111, 3'b111, {16'd3, 16'd2, 16'd1});
    for (int k = 1; k <= 30; k++) begin
      zero_pos[1] = (k == 10);
      vectors += 3;
      if (done[0] !== (k == 11)) begin miscompares++; $display("FAIL par_done0 k=%0d: got %b expected %b", k, done[0], k == 11); end
      if (done[1] !== (k == 19)) begin miscompares++; $display("FAIL par_done1 k=%0d: got %b expected %b", k, done[1], k == 19); end
      if (done[2] !== (k == 27)) begin miscompares++; $display("FAIL par_done2 k=%0d: got %b expected %b", k, done[2], k == 27); end
      if (k == 11) begin
        vectors += 3;
        if (pos[23:0] !== 24'd1)  begin miscompares++; $display("FAIL par_pos0: got %0d expected 1", pos[23:0]); end
        if (pos[47:24] !== 24'd0) begin miscompares++; $display("FAIL par_pos1_zero_wins: got %0d expected 0", pos[47:24]); end
        if (step[1] !== 1'b1)     begin miscompares++; $display("FAIL par_step1: got %b expected 1", step[1]); end
      end
      if (k == 27) begin
        vectors += 2;
        if (pos[47:24] !== 24'd0) begin miscompares++; $display("FAIL par_pos1_end: got %0d expected 0", pos[47:24]); end
        if (pos[71:48] !== 24'd3) begin miscompares++; $display("FAIL par_pos2: got %0d expected 3", pos[71:48]); end
      end
      @(negedge CLOCK_50);
    end
    zero_pos = 3'b000;
  endtask

  task automatic test_reset_mid_high();
    start_cmd(3'b001, 3'b001, {16'd0, 16'd0, 16'd2});
    repeat (3) @(negedge CLOCK_50);
    vectors++;
    if (step[0] !== 1'b1) begin miscompares++; $display("FAIL rst_pre_step: got %b expected 1", step[0]); end
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (step !== 3'b000) begin miscompares++; $display("FAIL rst_async_step: got %b expected 000", step); end
    if (busy !== 3'b000) begin miscompares++; $display("FAIL rst_async_busy: got %b expected 000", busy); end
    if (pos !== 72'h0)   begin miscompares++; $display("FAIL rst_async_pos: got %h expected 0", pos); end
    if (cmd_if.cmd_ready !== 3'b111) begin miscompares++; $display("FAIL rst_async_ready: got %b expected 111", cmd_if.cmd_ready); end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    start_cmd(3'b001, 3'b001, {16'd0, 16'd0, 16'd1});
    for (int k = 1; k <= 12; k++) begin
      vectors += 2;
      if (step[0] !== (k >= 3 && k <= 6)) begin miscompares++; $display("FAIL rst_new_step k=%0d: got %b expected %b", k, step[0], k >= 3 && k <= 6); end
      if (done[0] !== (k == 11)) begin miscompares++; $display("FAIL rst_new_done k=%0d: got %b expected %b", k, done[0], k == 11); end
      if (k == 11) begin
        vectors++;
        if (pos[23:0] !== 24'd1) begin miscompares++; $display("FAIL rst_new_pos: got %0d expected 1", pos[23:0]); end
      end
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    cmd_if.cmd_valid = 3'b000;
    cmd_if.cmd_dir   = 3'b000;
    cmd_if.cmd_steps = 48'h0;
    abort            = 3'b000;
    zero_pos         = 3'b000;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    test_reset();
    test_single_move();
    test_back_to_back();
    test_abort();
    test_zero_steps();
    test_parallel();
    test_reset_mid_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
